// File: rtl/tte_pkg.sv
// Shared types and sizing helpers for the programmable truth-table engine.
package tte_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } tte_state_e;

  // Per-output ones count must hold 2^n_in, hence one extra bit.
  function automatic int tte_cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int tte_depth(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tte_table.sv
// 2^N_IN x N_OUT truth-table register file: one synchronous write port,
// two asynchronous read ports (eval and sweep), cleared on rst.
module tte_table
  import tte_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [N_IN-1:0]  waddr,
  input  logic [N_OUT-1:0] wdata,
  input  logic [N_IN-1:0]  eval_addr,
  output logic [N_OUT-1:0] eval_data,
  input  logic [N_IN-1:0]  swp_addr,
  output logic [N_OUT-1:0] swp_data
);

  localparam int DEPTH = tte_depth(N_IN);

  logic [N_OUT-1:0] mem_q [DEPTH];
  logic [N_OUT-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Reads see the pre-edge contents, so a same-cycle write is not visible.
  assign eval_data = mem_q[eval_addr];
  assign swp_data  = mem_q[swp_addr];

endmodule

// File: rtl/truth_table_engine.sv
// Programmable truth-table evaluator with valid/ready eval stage and an
// exhaustive minterm-count sweep. Optional out_addr echo: TTE_ADDR_ECHO_EN.
module truth_table_engine
  import tte_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [N_IN-1:0]               cfg_addr,
  input  logic [N_OUT-1:0]              cfg_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_IN-1:0]               in_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_OUT-1:0]              out_vec,
`ifdef TTE_ADDR_ECHO_EN
  output logic [N_IN-1:0]               out_addr,
`endif
  input  logic                          sweep_start,
  output logic                          sweep_busy,
  output logic                          sweep_done,
  output logic [N_OUT*(N_IN+1)-1:0]     sweep_sig
);

  localparam int DEPTH = tte_depth(N_IN);
  localparam int CW    = tte_cnt_w(N_IN);
  localparam int AW    = N_IN + 1;

  tte_state_e                 state_q, state_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [N_OUT-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [N_OUT-1:0][CW-1:0]   sig_q, sig_d;
  logic                       out_valid_q, out_valid_d;
  logic [N_OUT-1:0]           out_vec_q, out_vec_d;
`ifdef TTE_ADDR_ECHO_EN
  logic [N_IN-1:0]            out_addr_q, out_addr_d;
`endif

  logic                       tbl_we;
  logic                       fire;
  logic [N_OUT-1:0]           eval_data;
  logic [N_OUT-1:0]           swp_data;

  assign tbl_we = cfg_we && (state_q == IDLE);

  tte_table #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .we        (tbl_we),
    .waddr     (cfg_addr),
    .wdata     (cfg_data),
    .eval_addr (in_vec),
    .eval_data (eval_data),
    .swp_addr  (addr_q[N_IN-1:0]),
    .swp_data  (swp_data)
  );

  assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
`ifdef TTE_ADDR_ECHO_EN
    out_addr_d  = out_addr_q;
`endif
    if (fire) begin
      out_valid_d = 1'b1;
      out_vec_d   = eval_data;
`ifdef TTE_ADDR_ECHO_EN
      out_addr_d  = in_vec;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE: begin
        if (sweep_start) begin
          state_d = SWEEP;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        for (int k = 0; k < N_OUT; k++) begin
          cnt_d[k] = cnt_q[k] + CW'(swp_data[k]);
        end
        addr_d = addr_q + AW'(1);
        // Latch the final totals (including the last entry) on entry to DONE.
        if (addr_q == AW'(DEPTH - 1)) begin
          state_d = DONE;
          sig_d   = cnt_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      sig_q       <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
`ifdef TTE_ADDR_ECHO_EN
      out_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
`ifdef TTE_ADDR_ECHO_EN
      out_addr_q  <= out_addr_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_vec    = out_vec_q;
`ifdef TTE_ADDR_ECHO_EN
  assign out_addr   = out_addr_q;
`endif
  assign sweep_busy = (state_q != IDLE);
  assign sweep_done = (state_q == DONE);
  assign sweep_sig  = sig_q;

endmodule

// File: tb/tb_truth_table_engine.sv
// Self-checking bench for truth_table_engine: behavioural model plus directed
// and randomized stimulus.
module tb_truth_table_engine;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int SW    = N_OUT * CW;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [N_IN-1:0]   cfg_addr;
  logic [N_OUT-1:0]  cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_vec;
`ifdef TTE_ADDR_ECHO_EN
  logic [N_IN-1:0]   out_addr;
`endif
  logic              sweep_start;
  logic              sweep_busy;
  logic              sweep_done;
  logic [SW-1:0]     sweep_sig;

  always #5 clk = ~clk;

  truth_table_engine #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vec     (out_vec),
`ifdef TTE_ADDR_ECHO_EN
    .out_addr    (out_addr),
`endif
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_sig   (sweep_sig)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference table contents used by the directed tests.
  function automatic int tt_ref(input int m);
    int b1, b0;
    b1 = (m inside {4, 5, 6, 7, 11, 12, 13}) ? 1 : 0;
    b0 = (m inside {1, 2, 4, 5}) ? 1 : 0;
    return b1 * 2 + b0;
  endfunction

  // Behavioural model: m_cnt counts remaining busy cycles (0 = idle,
  // 1 = the done cycle); the signature is a popcount taken at sweep start.
  int  m_tbl [DEPTH];
  bit  m_ov;
  int  m_ovec;
  int  m_oaddr;
  int  m_cnt;
  int  m_pend [N_OUT];
  int  m_sig  [N_OUT];
  bit  m_idle, m_rdy;
  bit  chk_en = 1'b0;

  function automatic int sig_pack();
    int s = 0;
    for (int k = 0; k < N_OUT; k++) s |= m_sig[k] << (k * CW);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) m_tbl[a] = 0;
      for (int k = 0; k < N_OUT; k++) begin m_sig[k] = 0; m_pend[k] = 0; end
      m_ov = 0; m_ovec = 0; m_oaddr = 0; m_cnt = 0;
    end else begin
      m_idle = (m_cnt == 0);
      m_rdy  = m_idle && (!m_ov || out_ready);
      if (in_valid && m_rdy) begin
        m_ov = 1; m_ovec = m_tbl[in_vec]; m_oaddr = int'(in_vec);
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (cfg_we && m_idle) m_tbl[cfg_addr] = int'(cfg_data);
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 1) for (int k = 0; k < N_OUT; k++) m_sig[k] = m_pend[k];
      end else if (sweep_start) begin
        m_cnt = DEPTH + 1;
        for (int k = 0; k < N_OUT; k++) begin
          m_pend[k] = 0;
          for (int a = 0; a < DEPTH; a++) m_pend[k] += (m_tbl[a] >> k) & 1;
        end
      end
    end
  end

  initial begin
    wait (chk_en);
    forever begin
      @(posedge clk);
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_vec", 64'(out_vec), 64'(m_ovec));
`ifdef TTE_ADDR_ECHO_EN
      chk("out_addr", 64'(out_addr), 64'(m_oaddr));
`endif
      chk("sweep_busy", 64'(sweep_busy), 64'(m_cnt > 0));
      chk("sweep_done", 64'(sweep_done), 64'(m_cnt == 1));
      chk("sweep_sig", 64'(sweep_sig), 64'(sig_pack()));
      @(negedge clk);
      #2;
      chk("in_ready", 64'(in_ready), 64'(!rst && m_cnt == 0 && (!m_ov || out_ready)));
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 2'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic eval_chk(input string name, input int v, input int exp);
    @(negedge clk);
    in_valid = 1'b1; in_vec = 4'(v);
    @(negedge clk);
    in_valid = 1'b0;
    chk(name, 64'(out_vec), 64'(exp));
    chk({name, "_vld"}, 64'(out_valid), 64'(1));
  endtask

  task automatic run_sweep(input bit poke, output int busy, output int dones);
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    busy = 0; dones = 0;
    while (sweep_busy && busy < 100) begin
      if (sweep_done) dones++;
      busy++;
      if (poke && busy == 5) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = 2'b11;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    int got[$];
    int i, guard, busy, dones;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; sweep_start = 1'b0;

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_vec", 64'(out_vec), 64'(0));
    chk("rst_busy", 64'(sweep_busy), 64'(0));
    chk("rst_done", 64'(sweep_done), 64'(0));
    chk("rst_sig", 64'(sweep_sig), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    eval_chk("eval_1010_cleared", 4'b1010, 0);

    for (int a = 0; a < DEPTH; a++) wr(a, tt_ref(a));
    eval_chk("eval_0101", 4'b0101, 2'b11);
    eval_chk("eval_1011", 4'b1011, 2'b10);
    eval_chk("eval_0010", 4'b0010, 2'b01);

    // Same-cycle write and eval of address 3 must return the old entry.
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 2'b11;
    in_valid = 1'b1; in_vec = 4'd3;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("rbw_old", 64'(out_vec), 64'(0));
    eval_chk("rbw_new", 3, 2'b11);
    wr(3, 0);

    // Stream 0..15 with out_ready toggling.
    i = 0; guard = 0;
    while (got.size() < 16 && guard < 200) begin
      @(negedge clk);
      in_valid  = (i < 16);
      in_vec    = 4'(i);
      out_ready = guard[0];
      #1;
      if (in_valid && in_ready) i++;
      if (out_valid && out_ready) got.push_back(int'(out_vec));
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 64'(got.size()), 64'(16));
    for (int j = 0; j < got.size() && j < 16; j++) chk("bp_order", 64'(got[j]), 64'(tt_ref(j)));

    run_sweep(1'b1, busy, dones);
    chk("sweep1_busy_len", 64'(busy), 64'(17));
    chk("sweep1_done_pulses", 64'(dones), 64'(1));
    chk("sweep1_sig", 64'(sweep_sig), 64'(10'b00111_00100));
    eval_chk("we_during_sweep", 0, 0);

    for (int a = 0; a < DEPTH; a++) wr(a, 3);
    run_sweep(1'b0, busy, dones);
    chk("ones_sig", 64'(sweep_sig), 64'({5'd16, 5'd16}));

    // Reset in the middle of a sweep.
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(sweep_busy), 64'(0));
    chk("abort_sig", 64'(sweep_sig), 64'(0));
    eval_chk("abort_table_cleared", 5, 0);
    run_sweep(1'b0, busy, dones);
    chk("abort_resweep_done", 64'(dones), 64'(1));
    chk("abort_resweep_sig", 64'(sweep_sig), 64'(0));

    repeat (3000) begin
      @(negedge clk);
      in_valid    = 1'($urandom_range(0, 1));
      in_vec      = 4'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      cfg_we      = ($urandom_range(0, 3) == 0);
      cfg_addr    = 4'($urandom);
      cfg_data    = 2'($urandom);
      sweep_start = ($urandom_range(0, 40) == 0);
      rst         = ($urandom_range(0, 600) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; sweep_start = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (25) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_engine.md
Name: truth_table_engine

Overview:
Programmable, parametrised successor to the team's fixed minterm decoders. An N_IN-input, N_OUT-output truth table is held in a writable register file instead of hard-wired gates. Input vectors are evaluated through a registered valid/ready stage. A built-in sweep sequencer walks all 2^N_IN input codes and reports a per-output minterm count, replacing hand-written exhaustive benches.

Parameters:
N_IN, 4, number of input variables; table depth = 2^N_IN (legal 1..8)
N_OUT, 2, number of output functions (table entry width, legal 1..16)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cfg_we  in  1  table write strobe
cfg_addr  in  N_IN  table entry (minterm index) to write
cfg_data  in  N_OUT  output bits for that minterm
in_valid  in  1  evaluation request valid
in_ready  out  1  engine can accept in_vec this cycle
in_vec  in  N_IN  input vector, MSB = first variable
out_valid  out  1  out_vec holds a result
out_ready  in  1  consumer accepts result
out_vec  out  N_OUT  table[in_vec]
sweep_start  in  1  start exhaustive sweep (sampled only in IDLE)
sweep_busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse when sweep_sig is valid
sweep_sig  out  N_OUT*(N_IN+1)  per-output ones count; field k = bits [k*(N_IN+1) +: N_IN+1]

Behaviour:
- Reset: all table entries 0. in_ready=0 during rst, then 1. out_valid=0, out_vec=0, sweep_busy=0, sweep_done=0, sweep_sig=0. State=IDLE.
- Table write: entry updates at the clk edge when cfg_we=1 and state=IDLE. cfg_we is ignored (no write) while SWEEP or DONE.
- Read-before-write: an eval or sweep read of the address written in the same cycle returns the old data.
- Eval handshake: in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer fires when in_valid && in_ready.
- Eval latency: out_vec/out_valid are registered 1 cycle after the transfer. out_vec is held stable while out_valid && !out_ready.
- Full throughput: one result per cycle when out_ready is held high.
- FSM states IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when sweep_start=1. If in_valid also fires that cycle, the eval is accepted and sweep_start takes priority for the state change.
  - Entering SWEEP clears the counters and sets addr counter = 0.
  - SWEEP: each cycle read table[addr] and add each bit k to count k; addr increments. After addr = 2^N_IN-1 is processed -> DONE.
  - Sweep length is exactly 2^N_IN cycles. sweep_busy=1 in SWEEP and DONE.
  - DONE: sweep_sig registers the counts, sweep_done=1 for that cycle only -> IDLE.
  - sweep_sig holds its value until the next sweep's DONE or reset.
- During a sweep: in_ready=0. A pending out_valid result stays valid and may still be consumed.
- Count width is N_IN+1, so an all-ones column (2^N_IN) does not overflow.
- Address counter width is N_IN+1 so the wrap at 2^N_IN terminates cleanly without aliasing to 0.
- rst mid-sweep: aborts immediately, no sweep_done pulse, sweep_sig=0, table cleared.
- sweep_start while in SWEEP/DONE: ignored.

Optional Feature:
TTE_ADDR_ECHO_EN
- Defined: adds output port out_addr [N_IN], registered alongside out_vec with the in_vec that produced it. It obeys the same hold rules and resets to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package tte_pkg: state enum {IDLE, SWEEP, DONE}, function returning count width (n_in+1), localparam helper for depth 1<<N_IN.
- Sub-module tte_table: 2^N_IN x N_OUT register file with synchronous write, asynchronous read, synchronous clear on rst. It has two read ports: eval and sweep.
- FSM, handshake and counters stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles -> all outputs 0. After release in_ready=1; eval of 4'b1010 returns out_vec=2'b00.
- Program table (N_IN=4, N_OUT=2): bit1 set at minterms {4,5,6,7,11,12,13}, bit0 set at {1,2,4,5}.
  - Eval 4'b0101 -> 2'b11 one cycle later.
  - Eval 4'b1011 -> 2'b10.
  - Eval 4'b0010 -> 2'b01.
- Backpressure: stream 0..15 with out_ready toggling 1/0 -> no result dropped or duplicated. out_vec stable while stalled; results in order.
- Sweep with the table above: pulse sweep_start -> sweep_busy for 17 cycles, sweep_done single pulse. sweep_sig field1=7, field0=4 (sweep_sig=10'b00111_00100).
- Boundaries:
  - All-ones table sweep -> each field = 16.
  - cfg_we during sweep has no effect: entry unchanged afterwards.
  - Same-cycle write+eval of addr 3 returns the old value.
- rst at sweep cycle 8 -> no sweep_done, sweep_sig=0, table cleared. A new sweep afterwards returns all zeros.
